// File: rtl/router_pkg.sv
// Shared constants and helpers for the router packet source.
package router_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;

    // The router has three output ports; address 3 does not exist.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Header byte: payload length in the upper six bits, port in the lower two.
    function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] dst);
        return {len, dst};
    endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload store: one byte per entry, written by the host, read by byte index.
module pkt_tx_buf #(
    parameter int MAX_LEN = 63,
    parameter int AW      = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MAX_LEN];

    // Contents need no reset; the fill level in the parent decides what is valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Frames a buffered payload as header/payload/parity onto the router input,
// honouring busy back-pressure, then samples router err to grade the packet.
import router_pkg::*;

module router_pkt_tx #(
    parameter int MAX_LEN   = 63,
    parameter int CHECK_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic       busy,
    input  logic       err,
    output logic [7:0] d_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic [5:0] count,
    output logic       done,
    output logic       pkt_err,
    output logic       cmd_err
);

    localparam logic [7:0] WIN_LAST = 8'(CHECK_CYC - 1);

    logic [2:0] state;
    logic [5:0] idx;
    logic [1:0] dest_q;
    logic [7:0] parity;
    logic [7:0] win;
    logic       err_seen;
    logic [7:0] header;
    logic [7:0] rd_data;
    logic       buf_we;

    assign header = pack_header(count, dest_q);

    // A start in the same cycle wins over a host write; a full buffer drops it.
    assign buf_we = (state == S_IDLE) && wr_en && !start && (count < 6'(MAX_LEN));

    pkt_tx_buf #(.MAX_LEN(MAX_LEN), .AW(6)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (count),
        .wdata (wr_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    // Outputs decode straight from state so a reset drops pkt_valid immediately.
    always_comb begin
        d_out     = 8'h00;
        pkt_valid = 1'b0;
        case (state)
            S_HEADER:  begin d_out = header;  pkt_valid = 1'b1; end
            S_PAYLOAD: begin d_out = rd_data; pkt_valid = 1'b1; end
            S_PARITY:  d_out = parity;
            default:   ;
        endcase
    end

    assign tx_active = (state != S_IDLE);

    // Main sequencer: buffer fill, start decode, byte stepping and err window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            count    <= 6'd0;
            idx      <= 6'd0;
            dest_q   <= 2'd0;
            parity   <= 8'h00;
            win      <= 8'd0;
            err_seen <= 1'b0;
            done     <= 1'b0;
            pkt_err  <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count == 6'd0 || dest == ADDR_INVALID) begin
                            cmd_err <= 1'b1;
                        end else begin
                            dest_q <= dest;
                            state  <= S_HEADER;
                        end
                    end else if (buf_we) begin
                        count <= count + 6'd1;
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        parity <= header;
                        idx    <= 6'd0;
                        state  <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        parity <= parity ^ rd_data;
                        idx    <= idx + 6'd1;
                        if (idx == count - 6'd1) state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        win      <= 8'd0;
                        err_seen <= 1'b0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    err_seen <= err_seen | err;
                    win      <= win + 8'd1;
                    if (win == WIN_LAST) begin
                        done    <= 1'b1;
                        pkt_err <= err_seen | err;
                        count   <= 6'd0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised bench for router_pkt_tx against a byte-stream reference model.
module tb_router_pkt_tx;

    localparam int MAX_LEN   = 63;
    localparam int CHECK_CYC = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, start, busy, err;
    logic [7:0] wr_data;
    logic [1:0] dest;
    logic [7:0] d_out;
    logic       pkt_valid, tx_active, done, pkt_err, cmd_err;
    logic [5:0] count;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q[$];          // model of buffered payload
    logic       pkt_err_exp = 1'b0;
    int         hold[0:127];   // forced busy cycles per stream position

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .CHECK_CYC(CHECK_CYC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
        .dest(dest), .busy(busy), .err(err), .d_out(d_out), .pkt_valid(pkt_valid),
        .tx_active(tx_active), .count(count), .done(done), .pkt_err(pkt_err),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1; wr_data = b;
        if (q.size() < MAX_LEN) q.push_back(b);
    endtask

    task automatic settle();
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic reject(input logic [1:0] d);
        @(negedge clk);
        start = 1'b1; dest = d; wr_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("rej_cmd_err", 32'(cmd_err), 1);
        chk("rej_valid", 32'(pkt_valid), 0);
        chk("rej_active", 32'(tx_active), 0);
        @(negedge clk);
        chk("rej_cmd_err_clr", 32'(cmd_err), 0);
        chk("rej_count", 32'(count), 32'(q.size()));
    endtask

    task automatic send(input logic [1:0] d, input int stall_pct, input int err_at,
                        input bit with_wr, input int abort_at);
        logic [7:0] s[$];
        logic [7:0] par;
        int n, pos, guard;
        bit b;
        n = q.size();
        s.push_back({6'(n), d});
        foreach (q[i]) s.push_back(q[i]);
        par = 8'h00;
        foreach (s[i]) par = par ^ s[i];
        s.push_back(par);

        @(negedge clk);
        start = 1'b1; dest = d; wr_en = with_wr; wr_data = 8'($urandom);
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        dest = 2'($urandom);
        chk("tx_active_start", 32'(tx_active), 1);
        pos = 0; guard = 0;
        while (pos <= n + 1 && guard < 5000) begin
            if (abort_at >= 0 && pos == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_valid", 32'(pkt_valid), 0);
                chk("abort_count", 32'(count), 0);
                chk("abort_active", 32'(tx_active), 0);
                q.delete();
                pkt_err_exp = 1'b0;
                @(negedge clk);
                rst = 1'b1; busy = 1'b0; wr_en = 1'b0; start = 1'b0;
                return;
            end
            chk("d_out", 32'(d_out), 32'(s[pos]));
            chk("pkt_valid", 32'(pkt_valid), 32'(pos <= n));
            chk("count_hold", 32'(count), 32'(n));
            chk("cmd_err_tx", 32'(cmd_err), 0);
            if (hold[pos] > 0) begin
                hold[pos]--;
                b = 1'b1;
            end else begin
                b = ($urandom_range(99) < stall_pct);
            end
            busy    = b;
            wr_en   = 1'($urandom_range(1));
            wr_data = 8'($urandom);
            start   = ($urandom_range(7) == 0);
            @(negedge clk);
            if (!b) pos++;
            guard++;
        end
        if (guard >= 5000) chk("stream_timeout", 1, 0);
        busy = 1'b0;
        for (int k = 0; k < CHECK_CYC; k++) begin
            chk("check_valid", 32'(pkt_valid), 0);
            chk("check_dout", 32'(d_out), 0);
            chk("check_done", 32'(done), 0);
            err   = (k == err_at);
            wr_en = 1'($urandom_range(1));
            start = 1'($urandom_range(1));
            @(negedge clk);
        end
        err = 1'b0; wr_en = 1'b0; start = 1'b0;
        pkt_err_exp = (err_at >= 0 && err_at < CHECK_CYC);
        chk("done", 32'(done), 1);
        chk("pkt_err", 32'(pkt_err), 32'(pkt_err_exp));
        chk("done_count", 32'(count), 0);
        chk("done_active", 32'(tx_active), 0);
        q.delete();
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("pkt_err_hold", 32'(pkt_err), 32'(pkt_err_exp));
        chk("idle_count", 32'(count), 0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; start = 1'b0; busy = 1'b0; err = 1'b0;
        wr_data = 8'h00; dest = 2'd0;
        for (int i = 0; i < 128; i++) hold[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(d_out), 0);
        chk("rst_valid", 32'(pkt_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_active", 32'(tx_active), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pkt_err", 32'(pkt_err), 0);
        chk("rst_cmd_err", 32'(cmd_err), 0);
        rst = 1'b1;

        // empty buffer start is refused
        reject(2'd1);

        // basic three-byte packet, no stalls
        put(8'hA1); put(8'hB2); put(8'hC3); settle();
        chk("count3", 32'(count), 3);
        send(2'd1, 0, -1, 0, -1);

        // same packet with stalls on header and on B2
        put(8'hA1); put(8'hB2); put(8'hC3); settle();
        hold[0] = 2; hold[2] = 3;
        send(2'd1, 0, -1, 0, -1);

        // invalid port refused, then err inside window, then clean packet
        put(8'h11); put(8'h22); settle();
        reject(2'd3);
        send(2'd0, 20, 1, 0, -1);
        for (int i = 0; i < 5; i++) put(8'($urandom));
        settle();
        send(2'd2, 20, -1, 0, -1);

        // saturation: 64 writes keep 63
        for (int i = 0; i < 64; i++) put(8'($urandom));
        settle();
        chk("count_sat", 32'(count), 63);
        send(2'd2, 30, -1, 0, -1);

        // random packets, including start colliding with a write
        for (int p = 0; p < 8; p++) begin
            int len;
            len = $urandom_range(20, 1);
            for (int i = 0; i < len; i++) put(8'($urandom));
            settle();
            chk("count_rand", 32'(count), 32'(q.size()));
            send(2'($urandom_range(2)), $urandom_range(50), $urandom_range(CHECK_CYC + 1) - 1,
                 1'($urandom_range(1)), -1);
        end

        // reset in the middle of the payload, then recover
        for (int i = 0; i < 10; i++) put(8'($urandom));
        settle();
        send(2'd1, 0, -1, 0, 4);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_pkt_err", 32'(pkt_err), 0);
        for (int i = 0; i < 4; i++) put(8'($urandom));
        settle();
        send(2'd0, 25, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source that drives the input side of the 1x3 router.
- A host first loads payload bytes into an internal buffer, then issues start with a destination port.
- The block frames and streams the packet onto the router input (header, payload, parity), stalling whenever the router asserts busy.
- After the parity byte it watches the router's err line and reports a per-packet completion status.

Parameters:
MAX_LEN, 63, maximum payload bytes; buffer depth; must fit the 6-bit header length field.
CHECK_CYC, 3, cycles after parity acceptance during which router err is sampled.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
wr_en  in  1  host payload write strobe
wr_data  in  8  host payload byte
start  in  1  host request to send the buffered packet
dest  in  2  destination port 0..2, sampled with start
busy  in  1  router busy; a byte is accepted only on an edge where busy==0
err  in  1  router parity error indication
d_out  out  8  byte to router d_in
pkt_valid  out  1  to router; high for header and payload bytes
tx_active  out  1  high from start acceptance until done
count  out  6  payload bytes currently buffered
done  out  1  one-cycle pulse at end of packet
pkt_err  out  1  valid with done; 1 if err was seen in the check window
cmd_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (async, rst==0): state IDLE; count=0; d_out=0; pkt_valid=0; tx_active=0; done=0; pkt_err=0; cmd_err=0; parity accumulator 0.
- Buffer writes:
  - In IDLE with count<MAX_LEN, wr_en stores wr_data at index count and count increments next cycle.
  - Writes outside IDLE, or with count==MAX_LEN, are dropped silently.
- Header format: {count[5:0], dest[1:0]}.
- Parity: XOR of the header and all payload bytes.
- Start handling, IDLE only:
  - start with count==0 or dest==2'b11: reject. cmd_err pulses the next cycle; state and buffer are unchanged.
  - Otherwise: capture dest; go to HEADER the next cycle; tx_active=1.
  - start outside IDLE is ignored; no cmd_err.
  - start with wr_en in the same IDLE cycle: the write is not applied, and the header length is the pre-write count.
- HEADER: d_out=header, pkt_valid=1, parity=header. Hold while busy==1. On an edge with busy==0, go to PAYLOAD with idx=0.
- PAYLOAD:
  - d_out=buf[idx], pkt_valid=1.
  - On busy==0: parity ^= buf[idx] and idx increments.
  - When idx==count-1 is accepted, go to PARITY.
  - While busy==1, d_out and pkt_valid stay stable. There are no bubbles: pkt_valid never drops inside the payload.
- PARITY: pkt_valid=0, d_out=parity. On busy==0, go to CHECK with the window counter at 0.
- CHECK:
  - d_out=0, pkt_valid=0.
  - err_seen |= err each cycle for CHECK_CYC cycles.
  - After the last cycle: done=1 for one cycle; pkt_err=err_seen, held until the next done; count cleared; tx_active=0; return to IDLE.
- Back-to-back packets: at least one IDLE cycle with pkt_valid=0 separates packets.
- Reset mid-packet: immediate abort; pkt_valid drops asynchronously; the buffer contents are lost.
- Latency: for a packet of N bytes with no stall, the header appears 1 cycle after start is accepted, parity at cycle N+2, and done at cycle N+3+CHECK_CYC.

Decomposition:
- Package router_pkg holds:
  - state encoding IDLE/HEADER/PAYLOAD/PARITY/CHECK
  - ADDR_INVALID=2'b11
  - header-packing function
- One sub-module, pkt_tx_buf:
  - MAX_LEN x 8 register array
  - write index and read port
  - synchronous write, combinational read by idx

Test Plan:
- Load A1,B2,C3; start dest=1, busy=0 -> d_out sequence 0D,A1,B2,C3,DD; pkt_valid 1,1,1,1,0; done pulses with pkt_err=0.
- Same packet with busy held high for 2 cycles at the header and 3 cycles at B2 -> bytes held stable, no duplicates or skips, same parity DD.
- start with count=0, and separately dest=3 with 2 bytes loaded -> cmd_err pulse, pkt_valid stays 0, count unchanged (0 / 2).
- Write 64 bytes -> count saturates at 63; send to dest=2 -> header 0xFE, 63 payload bytes, parity correct.
- Drive err=1 in the 2nd cycle after parity acceptance -> done with pkt_err=1; next clean packet -> pkt_err=0.
- Assert rst low in the middle of the payload -> pkt_valid=0 and count=0 immediately; after release, a new packet transmits correctly.
